// File: rtl/note_phase_inc_gen.sv
// rtl/note_phase_inc_gen.sv - note + bend to oscillator phase increment, time-shared
// Semitone base table with octave shifting, linear bend interpolation, clamp and saturation.
module note_phase_inc_gen #(
   parameter int NOTE_W    = 8,
   parameter int FRAC_W    = 7,
   parameter int BEND_W    = 14,
   parameter int VOICE_W   = 5,
   parameter int OUT_W     = 24,
   parameter int SHIFT_REF = 10
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [VOICE_W-1:0]       req_voice,
   input  logic [NOTE_W-1:0]        req_note,
   input  logic signed [BEND_W-1:0] req_bend,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [VOICE_W-1:0]       out_voice,
   output logic [OUT_W-1:0]         out_inc,
   output logic                     out_clamp,
   output logic                     out_sat
);

   localparam int P_W    = NOTE_W + FRAC_W + 2;
   localparam int EXT_W  = 13 + FRAC_W + 1;
   localparam int K_MAX  = ((2**NOTE_W) - 1) / 12;
   localparam int K_W    = (K_MAX < 1) ? 1 : $clog2(K_MAX + 1);
   localparam int SH_RAW = EXT_W + K_MAX;
   localparam int SH_W   = (SH_RAW > OUT_W) ? SH_RAW : OUT_W + 1;
   localparam logic [P_W-1:0] P_MAX = P_W'((2**NOTE_W - 1) * (2**FRAC_W));

   typedef enum logic [2:0] {IDLE, CLAMP, DIVIDE, INTERP, SHIFT, DONE} state_t;

   state_t                     state;
   logic [VOICE_W-1:0]         voice_q;
   logic [NOTE_W-1:0]          note_q;
   logic signed [BEND_W-1:0]   bend_q;
   logic [NOTE_W-1:0]          semi_q;
   logic [FRAC_W-1:0]          frac_q;
   logic [K_W-1:0]             k_q;
   logic [3:0]                 step_q;
   logic [EXT_W-1:0]           ext_q;
   logic                       clamp_q;

   function automatic logic [12:0] base_lut(input logic [3:0] idx);
      case (idx)
         4'd0:    base_lut = 13'd2608;
         4'd1:    base_lut = 13'd2763;
         4'd2:    base_lut = 13'd2927;
         4'd3:    base_lut = 13'd3101;
         4'd4:    base_lut = 13'd3286;
         4'd5:    base_lut = 13'd3481;
         4'd6:    base_lut = 13'd3688;
         4'd7:    base_lut = 13'd3908;
         4'd8:    base_lut = 13'd4140;
         4'd9:    base_lut = 13'd4386;
         4'd10:   base_lut = 13'd4647;
         4'd11:   base_lut = 13'd4923;
         4'd12:   base_lut = 13'd5216;
         default: base_lut = 13'd0;
      endcase
   endfunction

   logic signed [P_W-1:0] p_raw;
   logic [P_W-1:0]        p_c;
   logic                  clamp_c;
   logic [NOTE_W-1:0]     semi_c;
   logic [FRAC_W-1:0]     frac_c;

   // Effective pitch in fractional semitones, held inside [0, top note].
   always_comb begin
      p_raw   = $signed(P_W'({note_q, {FRAC_W{1'b0}}})) + P_W'(bend_q);
      p_c     = p_raw;
      clamp_c = 1'b0;
      if (p_raw[P_W-1]) begin
         p_c     = '0;
         clamp_c = 1'b1;
      end else if (p_c > P_MAX) begin
         p_c     = P_MAX;
         clamp_c = 1'b1;
      end
      semi_c = NOTE_W'(p_c >> FRAC_W);
      frac_c = p_c[FRAC_W-1:0];
   end

   logic [12:0]      b_lo;
   logic [12:0]      b_hi;
   logic [EXT_W-1:0] ext_c;
   logic [SH_W-1:0]  r_c;
   logic             sat_c;

   always_comb begin
      b_lo  = base_lut(step_q);
      b_hi  = base_lut(step_q + 4'd1);
      ext_c = {1'b0, b_lo, {FRAC_W{1'b0}}} + EXT_W'(b_hi - b_lo) * EXT_W'(frac_q);
      r_c   = (SH_W'(ext_q) << k_q) >> (SHIFT_REF + FRAC_W);
      sat_c = |r_c[SH_W-1:OUT_W];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         out_valid <= 1'b0;
         out_voice <= '0;
         out_inc   <= '0;
         out_clamp <= 1'b0;
         out_sat   <= 1'b0;
         voice_q   <= '0;
         note_q    <= '0;
         bend_q    <= '0;
         semi_q    <= '0;
         frac_q    <= '0;
         k_q       <= '0;
         step_q    <= '0;
         ext_q     <= '0;
         clamp_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  voice_q   <= req_voice;
                  note_q    <= req_note;
                  bend_q    <= req_bend;
                  req_ready <= 1'b0;
                  state     <= CLAMP;
               end
            end
            CLAMP: begin
               semi_q  <= semi_c;
               frac_q  <= frac_c;
               clamp_q <= clamp_c;
               k_q     <= '0;
               state   <= DIVIDE;
            end
            // Repeated subtraction: one octave per cycle.
            DIVIDE: begin
               if (semi_q >= NOTE_W'(12)) begin
                  semi_q <= semi_q - NOTE_W'(12);
                  k_q    <= k_q + K_W'(1);
               end else begin
                  step_q <= semi_q[3:0];
                  state  <= INTERP;
               end
            end
            INTERP: begin
               ext_q <= ext_c;
               state <= SHIFT;
            end
            SHIFT: begin
               out_inc   <= sat_c ? {OUT_W{1'b1}} : r_c[OUT_W-1:0];
               out_sat   <= sat_c;
               out_voice <= voice_q;
               out_clamp <= clamp_q;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
